// File: rtl/zpaq_fxa_pkg.sv
// Shared types and constants for the arithmetic encoder output packer.
package zpaq_fxa_pkg;

  localparam int unsigned PACK_IN_DW   = 8;
  localparam int unsigned PACK_OUT_DW  = 32;
  localparam int unsigned PACK_LANES   = PACK_OUT_DW / 8;
  localparam int unsigned PACK_LANE_W  = $clog2(PACK_LANES);
  localparam int unsigned PACK_KEEP_XW = PACK_LANES + 1;
  localparam int unsigned PACK_CNT_DW  = 32;

  typedef enum logic [1:0] {
    S_Run,
    S_Close,
    S_Drain
  } packer_state_t;

  typedef struct packed {
    logic [PACK_OUT_DW-1:0] tdata;
    logic [PACK_LANES-1:0]  tkeep;
    logic                   tlast;
  } axis_beat_t;

  // Low n_lanes bits set; n_lanes == 0 yields an empty mask.
  function automatic logic [PACK_LANES-1:0] keep_mask(input logic [PACK_LANE_W:0] n_lanes);
    logic [PACK_LANES:0] one_hot;
    one_hot = PACK_KEEP_XW'(1) << n_lanes;
    return PACK_LANES'(one_hot - PACK_KEEP_XW'(1));
  endfunction

endpackage

// File: rtl/arith_byte_packer_if.sv
// Byte-stream input, AXI4-Stream output and flush/count sideband of the packer.
interface arith_byte_packer_if;
  import zpaq_fxa_pkg::*;

  logic [PACK_IN_DW-1:0]  byteIn;
  logic                   byteValid;
  logic                   byteReady;
  logic                   flush;
  logic                   flushDone;
  logic [PACK_OUT_DW-1:0] m_tdata;
  logic [PACK_LANES-1:0]  m_tkeep;
  logic                   m_tlast;
  logic                   m_tvalid;
  logic                   m_tready;
  logic [PACK_CNT_DW-1:0] byteCount;

  // Encoder and sink side.
  modport master (
    output byteIn, byteValid, flush, m_tready,
    input  byteReady, flushDone, m_tdata, m_tkeep, m_tlast, m_tvalid, byteCount
  );

  // Packer side.
  modport slave (
    input  byteIn, byteValid, flush, m_tready,
    output byteReady, flushDone, m_tdata, m_tkeep, m_tlast, m_tvalid, byteCount
  );

endinterface

// File: rtl/arith_byte_packer_axis_out_reg.sv
// AXI4-Stream output holding register; contents only change when free, except
// that a held beat may be promoted to the block's last beat.
module axis_out_reg
  import zpaq_fxa_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_set_last,
  input  axis_beat_t i_beat,
  input  logic       i_ready,
  output axis_beat_t o_beat,
  output logic       o_valid
);

  axis_beat_t r_beat;
  logic       r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_beat  <= i_beat;
      r_valid <= 1'b1;
    end else if (i_set_last) begin
      r_beat.tlast <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_beat  = r_beat;
  assign o_valid = r_valid;

endmodule

// File: rtl/arith_byte_packer.sv
// Packs encoder bytes little-endian into 32-bit AXI4-Stream beats with flush/tlast.
// Define ARITH_PACKER_BYTECNT_EN to build the running byteCount register.
module arith_byte_packer
  import zpaq_fxa_pkg::*;
(
  input logic               clk,
  input logic               rst,
  arith_byte_packer_if.slave bus
);

  packer_state_t          r_state;
  packer_state_t          w_state_nxt;
  logic [PACK_OUT_DW-1:0] r_acc;
  logic [PACK_LANE_W-1:0] r_lane;

  logic                   w_out_free;
  logic                   w_lane_last;
  logic                   w_accept;
  logic                   w_byte_ready;
  logic                   w_load;
  logic                   w_set_last;
  logic                   w_flush_done;
  logic [PACK_OUT_DW-1:0] w_full_word;
  axis_beat_t             w_beat;
  axis_beat_t             w_out_beat;
  logic                   w_out_valid;

  assign w_out_free  = ~w_out_valid | bus.m_tready;
  assign w_lane_last = (r_lane == PACK_LANE_W'(PACK_LANES - 1));
  assign w_accept    = bus.byteValid & w_byte_ready;
  assign w_full_word = {bus.byteIn, r_acc[PACK_OUT_DW-PACK_IN_DW-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_Run;
    else     r_state <= w_state_nxt;
  end

  // Next state plus load/setLast/ready/flushDone controls; flushDone is
  // combinational so it coincides with the handshake of the tlast beat.
  always_comb begin
    w_state_nxt  = r_state;
    w_byte_ready = 1'b0;
    w_load       = 1'b0;
    w_set_last   = 1'b0;
    w_flush_done = 1'b0;
    w_beat       = '0;
    unique case (r_state)
      S_Run: begin
        w_byte_ready = ~w_lane_last | w_out_free;
        if (w_accept && w_lane_last) begin
          w_load       = 1'b1;
          w_beat.tdata = w_full_word;
          w_beat.tkeep = '1;
        end
        if (bus.flush) w_state_nxt = S_Close;
      end
      S_Close: begin
        // Accumulator is zero whenever lane is 0, so a lane-0 load is the null beat.
        if (r_lane == '0 && !w_out_free) begin
          w_set_last  = 1'b1;
          w_state_nxt = S_Drain;
        end else if (w_out_free) begin
          w_load       = 1'b1;
          w_beat.tdata = r_acc;
          w_beat.tkeep = keep_mask({1'b0, r_lane});
          w_beat.tlast = 1'b1;
          w_state_nxt  = S_Drain;
        end
      end
      S_Drain: begin
        if (w_out_valid && bus.m_tready && w_out_beat.tlast) begin
          w_flush_done = 1'b1;
          w_state_nxt  = S_Run;
        end
      end
      default: w_state_nxt = S_Run;
    endcase
  end

  // Accumulator lanes 0..LANES-2; the final lane goes straight to the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_lane <= '0;
    end else if (w_flush_done) begin
      r_acc  <= '0;
      r_lane <= '0;
    end else if (w_accept) begin
      if (w_lane_last) begin
        r_acc  <= '0;
        r_lane <= '0;
      end else begin
        r_acc[32'(r_lane) * PACK_IN_DW +: PACK_IN_DW] <= bus.byteIn;
        r_lane <= r_lane + PACK_LANE_W'(1);
      end
    end
  end

`ifdef ARITH_PACKER_BYTECNT_EN
  logic [PACK_CNT_DW-1:0] r_byte_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_byte_count <= '0;
    else if (w_flush_done) r_byte_count <= '0;
    else if (w_accept)     r_byte_count <= r_byte_count + PACK_CNT_DW'(1);
  end

  assign bus.byteCount = r_byte_count;
`else
  assign bus.byteCount = '0;
`endif

  axis_out_reg u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_set_last (w_set_last),
    .i_beat     (w_beat),
    .i_ready    (bus.m_tready),
    .o_beat     (w_out_beat),
    .o_valid    (w_out_valid)
  );

  assign bus.byteReady = w_byte_ready;
  assign bus.flushDone = w_flush_done;
  assign bus.m_tdata   = w_out_beat.tdata;
  assign bus.m_tkeep   = w_out_beat.tkeep;
  assign bus.m_tlast   = w_out_beat.tlast;
  assign bus.m_tvalid  = w_out_valid;

endmodule

// File: tb/tb_arith_byte_packer.sv
// Scoreboard bench for arith_byte_packer: directed blocks, stall, async reset, random stream.
module tb_arith_byte_packer;
  import zpaq_fxa_pkg::*;

`ifdef ARITH_PACKER_BYTECNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic ready_force;
  logic rnd_ready;
  logic rnd_bit;

  int n_cmp;
  int n_err;
  int n_beats;
  int n_exp_beats;
  int fd_seen;
  int fd_exp;

  axis_beat_t exp_q[$];

  arith_byte_packer_if bus ();

  arith_byte_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.m_tready = rnd_ready ? rnd_bit : ready_force;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    axis_beat_t b;
    b.tdata = d;
    b.tkeep = k;
    b.tlast = l;
    exp_q.push_back(b);
    n_exp_beats++;
  endtask

  // Monitor: every taken beat is compared against the head of the scoreboard.
  always @(negedge clk) begin
    axis_beat_t e;
    if (!rst && bus.m_tvalid && bus.m_tready) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        fail_now("unexpected_beat");
      end else begin
        e = exp_q.pop_front();
        chk("beat_tdata", 64'(bus.m_tdata), 64'(e.tdata));
        chk("beat_tkeep", 64'(bus.m_tkeep), 64'(e.tkeep));
        chk("beat_tlast", 64'(bus.m_tlast), 64'(e.tlast));
      end
    end
    if (!rst && bus.flushDone) fd_seen++;
  end

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    bus.byteValid = 1'b1;
    bus.byteIn    = b;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.byteReady;
      @(posedge clk);
      #1;
      n++;
    end
    bus.byteValid = 1'b0;
    if (!acc) fail_now("send_timeout");
  endtask

  // Pulses flush, optionally releases the sink, waits for flushDone and checks latency/count.
  task automatic do_flush(input int release_after, input int exp_lat, input int unsigned n_bytes);
    bit done;
    int k;
    int lat;
    done = 1'b0;
    k = 0;
    lat = -1;
    bus.flush = 1'b1;
    while (!done && k < 100) begin
      if (k == release_after) ready_force = 1'b1;
      @(negedge clk);
      if (k == 0) chk("bytecount_pre_flush", 64'(bus.byteCount), CNT_EN ? 64'(n_bytes) : 64'd0);
      if (bus.flushDone) begin
        done = 1'b1;
        lat = k;
      end
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      k++;
    end
    fd_exp++;
    if (!done) fail_now("flush_timeout");
    else if (exp_lat >= 0) chk("flush_latency", 64'(lat), 64'(exp_lat));
    @(negedge clk);
    chk("bytecount_post_flush", 64'(bus.byteCount), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rb [0:1001];
    logic [31:0] w;

    n_cmp = 0; n_err = 0; n_beats = 0; n_exp_beats = 0; fd_seen = 0; fd_exp = 0;
    rst = 1'b1;
    ready_force = 1'b1;
    rnd_ready = 1'b0;
    bus.byteIn = '0;
    bus.byteValid = 1'b0;
    bus.flush = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("rst_tdata", 64'(bus.m_tdata), 64'd0);
    chk("rst_tkeep", 64'(bus.m_tkeep), 64'd0);
    chk("rst_tlast", 64'(bus.m_tlast), 64'd0);
    chk("rst_flushdone", 64'(bus.flushDone), 64'd0);
    chk("rst_bytecount", 64'(bus.byteCount), 64'd0);
    chk("rst_byteready", 64'(bus.byteReady), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Five bytes, sink ready: full word then a one-lane last beat.
    push_exp(32'h44332211, 4'hF, 1'b0);
    push_exp(32'h00000055, 4'h1, 1'b1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    do_flush(0, 2, 5);

    // Eight bytes; second word held by a stalled sink gets tlast, no null beat.
    push_exp(32'h04030201, 4'hF, 1'b0);
    push_exp(32'h08070605, 4'hF, 1'b1);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    ready_force = 1'b0;
    for (int i = 6; i <= 8; i++) send_byte(8'(i));
    do_flush(4, -1, 8);

    // Exactly one word then flush with sink ready: a null last beat follows.
    push_exp(32'hDDCCBBAA, 4'hF, 1'b0);
    push_exp(32'h00000000, 4'h0, 1'b1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    do_flush(0, 2, 4);

    // Sink stalled for 10 cycles while bytes stream: ready drops only for the 4th-lane byte.
    push_exp(32'hA3A2A1A0, 4'hF, 1'b0);
    push_exp(32'hA7A6A5A4, 4'hF, 1'b0);
    push_exp(32'h00000000, 4'h0, 1'b1);
    begin
      int sent;
      bit rdy;
      sent = 0;
      ready_force = 1'b0;
      for (int k = 0; k < 10; k++) begin
        bus.byteValid = 1'b1;
        bus.byteIn = 8'(8'hA0 + sent);
        @(negedge clk);
        rdy = bus.byteReady;
        chk($sformatf("stall_byteready_%0d", k), 64'(rdy), (k < 7) ? 64'd1 : 64'd0);
        if (k >= 4) chk($sformatf("stall_tdata_%0d", k), 64'(bus.m_tdata), 64'hA3A2A1A0);
        @(posedge clk);
        #1;
        if (rdy) sent++;
      end
      bus.byteValid = 1'b0;
      ready_force = 1'b1;
      send_byte(8'(8'hA0 + sent));
    end
    do_flush(0, 2, 8);

    // Async reset mid-block discards the held word and the partial lanes.
    ready_force = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
    @(negedge clk);
    chk("pre_rst_tvalid", 64'(bus.m_tvalid), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("async_rst_tdata", 64'(bus.m_tdata), 64'd0);
    chk("async_rst_tkeep", 64'(bus.m_tkeep), 64'd0);
    chk("async_rst_byteready", 64'(bus.byteReady), 64'd1);
    chk("async_rst_bytecount", 64'(bus.byteCount), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp(32'hC3C2C1C0, 4'hF, 1'b1);
    send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    do_flush(4, -1, 4);

    // 1002 random bytes under a random ready pattern: 250 words plus a 2-lane last beat.
    for (int i = 0; i < 1002; i++) rb[i] = 8'($urandom);
    for (int i = 0; i < 250; i++) begin
      w = {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]};
      push_exp(w, 4'hF, 1'b0);
    end
    push_exp({16'h0000, rb[1001], rb[1000]}, 4'h3, 1'b1);
    rnd_ready = 1'b1;
    for (int i = 0; i < 1002; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_byte(rb[i]);
    end
    do_flush(0, -1, 1002);
    rnd_ready = 1'b0;
    ready_force = 1'b1;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("beat_total", 64'(n_beats), 64'(n_exp_beats));
    chk("flushdone_total", 64'(fd_seen), 64'(fd_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
